// File: rtl/mem_burst_ctrl.sv
// Burst bus master for the 8-bit synchronous memory: accepts read/write burst
// commands, drives rd/wr/addr strobes and the shared tri-state data bus.
module mem_burst_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [3:0] cmd_len,
   input  logic       wdata_valid,
   output logic       wdata_ready,
   input  logic [7:0] wdata,
   output logic       rdata_valid,
   output logic [7:0] rdata,
   output logic       done,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [7:0] mem_addr,
   inout  wire  [7:0] mem_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] addr, addr_nxt;
   logic [3:0] count, count_nxt;
   logic       done_nxt;
   logic       drive;
   // High in the cycle after a mem_rd cycle: the memory owns the bus then.
   logic       rd_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr        <= '0;
         count       <= '0;
         done        <= 1'b0;
         rd_q        <= 1'b0;
         rdata_valid <= 1'b0;
         rdata       <= '0;
      end else begin
         state       <= state_nxt;
         addr        <= addr_nxt;
         count       <= count_nxt;
         done        <= done_nxt;
         rd_q        <= mem_rd;
         rdata_valid <= rd_q;
         if (rd_q) begin
            rdata <= mem_data;
         end
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      count_nxt   = count;
      done_nxt    = 1'b0;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      drive       = 1'b0;

      unique case (state)
         IDLE: begin
            // Gated by rst_n so the handshake stays closed while reset is held.
            cmd_ready = rst_n;
            if (cmd_valid) begin
               addr_nxt  = cmd_addr;
               count_nxt = cmd_len;
               state_nxt = cmd_write ? WRITE : READ;
            end
         end
         WRITE: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               mem_wr    = 1'b1;
               drive     = 1'b1;
               addr_nxt  = addr + 8'd1;
               count_nxt = count - 4'd1;
               if (count == 4'd0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         READ: begin
            mem_rd    = 1'b1;
            addr_nxt  = addr + 8'd1;
            count_nxt = count - 4'd1;
            if (count == 4'd0) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign mem_addr = addr;
   assign mem_data = drive ? wdata : 8'hzz;

   no_bus_contention: assert property (@(posedge clk) disable iff (!rst_n) !(rd_q && drive));

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a synchronous memory model on the
// shared bus and a queue-based scoreboard checked by a separate monitor.
module tb_mem_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   logic       wdata_valid, wdata_ready;
   logic [7:0] wdata;
   logic       rdata_valid, done;
   logic [7:0] rdata;
   logic       mem_rd, mem_wr;
   logic [7:0] mem_addr;
   wire  [7:0] mem_data;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int exp_dones = 0;
   bit mon_en = 1'b0;

   logic [15:0] wr_q [$];
   logic [7:0]  rda_q [$];
   logic [7:0]  rdd_q [$];
   logic [7:0]  exp_mem [256];
   logic [7:0]  wbuf [16];

   always #5 clk = ~clk;

   mem_burst_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .wdata_valid(wdata_valid),
      .wdata_ready(wdata_ready),
      .wdata      (wdata),
      .rdata_valid(rdata_valid),
      .rdata      (rdata),
      .done       (done),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data)
   );

   // Undriven bus floats to 0xFF so released cycles are observable.
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (mem_data[g]);
   end

   // Synchronous memory model: drives read data the cycle after mem_rd.
   logic [7:0] mem_arr [256];
   logic       m_drv;
   logic [7:0] m_out;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_drv <= 1'b0;
      end else begin
         m_drv <= mem_rd;
         if (mem_rd) m_out <= mem_arr[mem_addr];
         if (mem_wr) mem_arr[mem_addr] <= mem_data;
      end
   end

   assign mem_data = m_drv ? m_out : 8'hzz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard queues whenever the DUT presents activity.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_rd) begin
            if (rda_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr", mem_addr, rda_q.pop_front());
         end
         if (mem_wr) begin
            if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else check("wr_addr_data", {mem_addr, mem_data}, wr_q.pop_front());
         end
         if (rdata_valid) begin
            if (rdd_q.size() == 0) check("rdata_unexpected", 1, 0);
            else check("rdata", rdata, rdd_q.pop_front());
         end
         if (done) done_cnt++;
         if (m_drv) check("bus_mem_owned", {mem_wr, mem_data}, {1'b0, m_out});
         else if (!mem_wr) check("bus_released", mem_data, 8'hFF);
      end
   end

   task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l);
      int n;
      n = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      @(negedge clk);
      while (!cmd_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic write_burst(input logic [7:0] a, input int n, input int gap, input bit pre);
      logic [7:0] ad;
      if (pre) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
      end else begin
         issue(1'b1, a, 4'(n - 1));
      end
      for (int i = 0; i < n; i++) begin
         ad = a + 8'(i);
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               wdata_valid = 1'b0;
               wdata       = 8'h00;
               @(negedge clk);
               check("gap_hold", {mem_wr, done, mem_addr, mem_data}, {1'b0, 1'b0, ad, 8'hFF});
               @(posedge clk); #1;
            end
         end
         wdata_valid = 1'b1;
         wdata       = wbuf[i];
         wr_q.push_back({ad, wbuf[i]});
         exp_mem[ad] = wbuf[i];
         @(negedge clk);
         check("wbeat_accept", {wdata_ready, done}, 2'b10);
         @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
      wdata       = 8'h00;
      @(negedge clk);
      check("wr_done_ready", {done, cmd_ready}, 2'b11);
      exp_dones++;
   endtask

   task automatic read_burst(input logic [7:0] a, input int n, input bit follow,
                             input logic [7:0] fa, input logic [3:0] fl);
      logic [31:0] rd_v, rv_v, dn_v, rdy_v, ones;
      logic [7:0]  ad;
      for (int i = 0; i < n; i++) begin
         ad = a + 8'(i);
         rda_q.push_back(ad);
         rdd_q.push_back(exp_mem[ad]);
      end
      issue(1'b0, a, 4'(n - 1));
      if (follow) begin
         cmd_valid = 1'b1;
         cmd_write = 1'b1;
         cmd_addr  = fa;
         cmd_len   = fl;
      end
      rd_v = '0; rv_v = '0; dn_v = '0; rdy_v = '0;
      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         rd_v[k]  = mem_rd;
         rv_v[k]  = rdata_valid;
         dn_v[k]  = done;
         rdy_v[k] = cmd_ready;
      end
      ones = (32'd1 << n) - 32'd1;
      check("rd_strobe_cycles", rd_v, ones << 1);
      check("rdata_valid_cycles", rv_v, ones << 3);
      check("rd_done_cycle", dn_v, 32'd1 << (n + 2));
      check("rd_ready_cycle", rdy_v, 32'd1 << (n + 2));
      exp_dones++;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int dn_before;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 8'(i) ^ 8'hC3;
         exp_mem[i] = 8'(i) ^ 8'hC3;
      end
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
      cmd_len = 4'h0; wdata_valid = 1'b0; wdata = 8'h00;
      #23;
      check("reset_ctrl", {cmd_ready, wdata_ready, rdata_valid, done, mem_rd, mem_wr}, 6'b0);
      check("reset_regs", {rdata, mem_addr}, 16'h0000);
      check("reset_bus", mem_data, 8'hFF);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", cmd_ready, 1);
      mon_en = 1'b1;

      // 4-beat write then read at 0x10
      wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
      write_burst(8'h10, 4, 0, 1'b0);
      read_burst(8'h10, 4, 1'b0, 8'h00, 4'h0);

      // Address wrap FE,FF,00,01
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
      write_burst(8'hFE, 4, 0, 1'b0);
      read_burst(8'hFE, 4, 1'b0, 8'h00, 4'h0);

      // Write with 2-cycle gaps between beats
      wbuf[0] = 8'h71; wbuf[1] = 8'h72; wbuf[2] = 8'h73;
      write_burst(8'h30, 3, 2, 1'b0);
      read_burst(8'h30, 3, 1'b0, 8'h00, 4'h0);

      // 16-beat read with a write command held pending from cycle 1
      wbuf[0] = 8'h99; wbuf[1] = 8'h9A;
      read_burst(8'h00, 16, 1'b1, 8'h80, 4'd1);
      write_burst(8'h80, 2, 0, 1'b1);
      read_burst(8'h80, 2, 1'b0, 8'h00, 4'h0);

      // Reset in cycle 5 of a 16-beat read: beats from cycles 1..2 only
      for (int i = 0; i < 4; i++) rda_q.push_back(8'h20 + 8'(i));
      rdd_q.push_back(exp_mem[8'h20]);
      rdd_q.push_back(exp_mem[8'h21]);
      issue(1'b0, 8'h20, 4'd15);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("mid_reset_ctrl", {cmd_ready, wdata_ready, rdata_valid, done, mem_rd, mem_wr}, 6'b0);
      check("mid_reset_regs", {rdata, mem_addr}, 16'h0000);
      check("mid_reset_bus", mem_data, 8'hFF);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_mid_reset", cmd_ready, 1);
      dn_before = done_cnt;
      repeat (20) @(negedge clk);
      check("no_done_after_reset", done_cnt, dn_before);

      // Single-beat read of 0x5A at 0x42
      wbuf[0] = 8'h5A;
      write_burst(8'h42, 1, 0, 1'b0);
      read_burst(8'h42, 1, 1'b0, 8'h00, 4'h0);

      repeat (4) @(negedge clk);
      check("done_total", done_cnt, exp_dones);
      check("wr_q_drained", wr_q.size(), 0);
      check("rda_q_drained", rda_q.size(), 0);
      check("rdd_q_drained", rdd_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
